// File: rtl/cond_pkg.sv
// cond_pkg: shared condition-code and flag definitions for the condition stage.
// Used by cond_check and cond_logic; the COND_STATS_EN macro affects cond_logic only.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Bit positions inside the flag_w request
    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational evaluation of a 4-bit condition field against NZCV flags.
// Code F is "never": the instruction is squashed.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       ex
);

    logic n, z, c, v;

    // Decode the condition field into a single execute/squash decision
    always_comb begin
        n  = flags[FLAG_N];
        z  = flags[FLAG_Z];
        c  = flags[FLAG_C];
        v  = flags[FLAG_V];
        ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: ex = z;
            COND_NE: ex = !z;
            COND_CS: ex = c;
            COND_CC: ex = !c;
            COND_MI: ex = n;
            COND_PL: ex = !n;
            COND_VS: ex = v;
            COND_VC: ex = !v;
            COND_HI: ex = c && !z;
            COND_LS: ex = !c || z;
            COND_GE: ex = (n == v);
            COND_LT: ex = (n != v);
            COND_GT: ex = !z && (n == v);
            COND_LE: ex = z || (n != v);
            COND_AL: ex = 1'b1;
            COND_NV: ex = 1'b0;
            default: ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// cond_logic: NZCV flag register plus a one-entry registered stage that gates
// PC/register/memory side effects by the instruction's condition.
// Optional macro COND_STATS_EN adds saturating execute/squash counters (CNT_W bits).
module cond_logic
    import cond_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] squash_count
`endif
);

    logic       accept;
    logic       ex;
    logic [3:0] flags_nxt;

    // Condition is evaluated against the flag register before this instruction's update
    cond_check u_check (
        .cond  (cond),
        .flags (flags),
        .ex    (ex)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Merge the selected ALU flag pairs into the current flags for an executing instruction
    always_comb begin
        flags_nxt = flags;
        if (accept && ex) begin
            if (flag_w[FW_NZ]) begin
                flags_nxt[FLAG_N] = alu_flags[FLAG_N];
                flags_nxt[FLAG_Z] = alu_flags[FLAG_Z];
            end
            if (flag_w[FW_CV]) begin
                flags_nxt[FLAG_C] = alu_flags[FLAG_C];
                flags_nxt[FLAG_V] = alu_flags[FLAG_V];
            end
        end
    end

    // Architectural flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else begin
            flags <= flags_nxt;
        end
    end

    // Output register: load on accept, clear on drain so gated outputs read 0 when empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            cond_ex   <= 1'b0;
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            cond_ex   <= ex;
            pc_src    <= pcs && ex;
            reg_write <= reg_w && ex;
            mem_write <= mem_w && ex;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            cond_ex   <= 1'b0;
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
        end
    end

`ifdef COND_STATS_EN
    // Saturating execute/squash statistics, counted per accepted instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_count   <= '0;
            squash_count <= '0;
        end else if (accept) begin
            if (ex && (exec_count != '1)) begin
                exec_count <= exec_count + CNT_W'(1);
            end
            if (!ex && (squash_count != '1)) begin
                squash_count <= squash_count + CNT_W'(1);
            end
        end
    end
`else
    // CNT_W only sizes the statistics counters, which are absent in this build
    if (CNT_W == 0) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed plus randomized stimulus for cond_logic with a queue-based
// scoreboard; counter checks are compiled in when COND_STATS_EN is defined.
module tb_cond_logic;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs, reg_w, mem_w;
    logic       out_valid;
    logic       out_ready;
    logic       pc_src, reg_write, mem_write, cond_ex;
    logic [3:0] flags;
`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_count, squash_count;
`endif

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cond         (cond),
        .alu_flags    (alu_flags),
        .flag_w       (flag_w),
        .pcs          (pcs),
        .reg_w        (reg_w),
        .mem_w        (mem_w),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .cond_ex      (cond_ex)
`ifdef COND_STATS_EN
        ,
        .flags        (flags),
        .exec_count   (exec_count),
        .squash_count (squash_count)
`else
        ,
        .flags        (flags)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0]  exp_q[$];   // {cond_ex, pc_src, reg_write, mem_write}
    logic [3:0]  m_flags;
    bit          m_valid;
    int unsigned m_exec, m_squash;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition truth: codes pair up as (predicate, inverse); F never executes
    function automatic bit passes(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        return cc[0] ? !base : base;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned x);
        return (x >= CNT_MAX) ? CNT_MAX : x + 1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_flags  = 4'b0000;
        m_valid  = 1'b0;
        m_exec   = 0;
        m_squash = 0;
    endtask

    // Drive one cycle of inputs, then update the model at the clock edge
    task automatic step(input bit v, input logic [3:0] cc, input logic [3:0] af,
                        input logic [1:0] fw, input bit p, input bit r, input bit m,
                        input bit ordy);
        bit acc, ex;
        in_valid  = v;
        cond      = cc;
        alu_flags = af;
        flag_w    = fw;
        pcs       = p;
        reg_w     = r;
        mem_w     = m;
        out_ready = ordy;
        acc = v && (!m_valid || ordy);
        ex  = passes(cc, m_flags);
        @(posedge clk);
        if (acc) begin
            exp_q.push_back({ex, p & ex, r & ex, m & ex});
            if (ex) begin
                if (fw[1]) m_flags[3:2] = af[3:2];
                if (fw[0]) m_flags[1:0] = af[1:0];
                m_exec = sat_inc(m_exec);
            end else begin
                m_squash = sat_inc(m_squash);
            end
            m_valid = 1'b1;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    // Monitor: compares handshake, flags and the presented result against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", in_ready, !m_valid || out_ready);
            check("out_valid", out_valid, m_valid);
            check("flags", flags, m_flags);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got out_valid 1 expected empty queue at %0t", $time);
                end else begin
                    check("result", {cond_ex, pc_src, reg_write, mem_write}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("gated_idle", {pc_src, reg_write, mem_write}, 3'b000);
            end
`ifdef COND_STATS_EN
            check("exec_count", exec_count, m_exec);
            check("squash_count", squash_count, m_squash);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; cond = 4'h0; alu_flags = 4'h0; flag_w = 2'b00;
        pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_flags", flags, 4'b0000);
        check("rst_gated", {cond_ex, pc_src, reg_write, mem_write}, 4'b0000);
`ifdef COND_STATS_EN
        check("rst_counts", {exec_count, squash_count}, 0);
`endif
        reset = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1'b1);
        mon_en = 1'b1;

        // AL with full flag write
        step(1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 1);
        check("al_valid", out_valid, 1'b1);
        check("al_cond_ex", cond_ex, 1'b1);
        check("al_flags", flags, 4'b0100);

        // EQ executes with Z=1, NE squashes
        step(1, 4'h0, 4'b1011, 2'b00, 0, 1, 0, 1);
        check("eq_reg_write", reg_write, 1'b1);
        step(1, 4'h1, 4'b1011, 2'b11, 0, 1, 0, 1);
        check("ne_cond_ex", cond_ex, 1'b0);
        check("ne_reg_write", reg_write, 1'b0);
        check("ne_flags", flags, 4'b0100);

        // Back-to-back dependency: compare sets N, then GE squashes, LT executes
        step(1, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 1);
        step(1, 4'hA, 4'b0000, 2'b00, 0, 1, 0, 1);
        check("ge_cond_ex", cond_ex, 1'b0);
        step(1, 4'hB, 4'b0000, 2'b00, 0, 1, 0, 1);
        check("lt_cond_ex", cond_ex, 1'b1);

        // Partial flag write from 0000, then never-code holds flags
        step(1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 1);
        step(1, 4'hE, 4'b1111, 2'b01, 0, 0, 0, 1);
        check("cv_flags", flags, 4'b0011);
        step(1, 4'hF, 4'b1111, 2'b11, 1, 1, 1, 1);
        check("nv_cond_ex", cond_ex, 1'b0);
        check("nv_flags", flags, 4'b0011);

        // Stall three cycles with a pending instruction, then release
        for (int i = 0; i < 3; i++) begin
            step(1, 4'hE, 4'b1100, 2'b11, 1, 1, 1, 0);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_flags", flags, 4'b0011);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 4'hE, 4'(i), 2'b11, 1, 0, 1, 1);
            check("release_valid", out_valid, 1'b1);
        end

        // Asynchronous reset while stalled
        step(1, 4'hE, 4'b1010, 2'b11, 0, 1, 0, 0);
        step(1, 4'hE, 4'b0101, 2'b11, 0, 1, 0, 0);
        mon_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_flags", flags, 4'b0000);
        check("async_gated", {cond_ex, pc_src, reg_write, mem_write}, 4'b0000);
        model_reset();
        reset = 1'b0;
        mon_en = 1'b1;

        // Five executes from reset saturate a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            step(1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 1);
        end
`ifdef COND_STATS_EN
        check("exec_sat", exec_count, 2'd3);
        check("squash_zero", squash_count, 2'd0);
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end

        // Drain
        for (int i = 0; i < 3; i++) begin
            step(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 1);
        end
        check("queue_empty", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
# cond_logic

- Consumes the 4-bit `{N,Z,C,V}` flag vector produced by the 32-bit ALU and holds the architectural NZCV flag register.
- Evaluates each instruction's 4-bit condition field against those flags.
- Gates the instruction's side effects (PC write, register write, memory write) and updates the flags when the instruction executes.
- Sits between the ALU/decoder and the writeback/fetch control as a one-entry registered pipeline stage with a valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, 16: width of the statistics counters (present only with `COND_STATS_EN`).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream instruction present.
- `in_ready`  out  1  stage can accept.
- `cond`  in  4  condition field.
- `alu_flags`  in  4  ALU flags `{N,Z,C,V}`, bit 3 = N.
- `flag_w`  in  2  flag write request. Bit 1 updates N,Z; bit 0 updates C,V.
- `pcs`, `reg_w`, `mem_w`  in  1 each  requested side effects.
- `out_valid`  out  1  registered result present.
- `out_ready`  in  1  downstream accepts.
- `pc_src`, `reg_write`, `mem_write`  out  1 each  gated side effects.
- `cond_ex`  out  1  held instruction passed its condition.
- `flags`  out  4  current flag register `{N,Z,C,V}`.
- `exec_count`, `squash_count`  out  `CNT_W`  present only with `COND_STATS_EN`.

## Operation
- `in_ready = !out_valid || out_ready` (combinational).
- Accept occurs when `in_valid && in_ready`.
- On accept, `ex = check(cond, flags)` is evaluated against the flag register value **before** this instruction's update.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 0 (treated as never; instruction squashed).
- On accept with `ex=1`:
  - `flag_w[1]` loads N,Z from `alu_flags[3:2]`.
  - `flag_w[0]` loads C,V from `alu_flags[1:0]`.
  - Flag bits not selected by `flag_w` hold.
- On accept with `ex=0`, flags hold.
- Output register loads on accept:
  - `cond_ex` = `ex`
  - `pc_src` = `pcs&ex`
  - `reg_write` = `reg_w&ex`
  - `mem_write` = `mem_w&ex`
  - `out_valid` = 1
- If `out_valid && out_ready` with no new accept, `out_valid` drops to 0. Gated outputs are forced to 0 whenever `out_valid` = 0.
- Simultaneous drain and accept: the new instruction replaces the old one in the same edge; throughput is 1/cycle.
- Stall (`out_valid && !out_ready`): all outputs and flags hold, and inputs are ignored.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- A flag update is visible on `flags`, and to the condition check of the next accepted instruction, on the edge after accept. Back-to-back dependent instructions therefore evaluate correctly with no bubble.
- Reset values: `flags`=0000, `out_valid`=0, `cond_ex`=0, `pc_src`=0, `reg_write`=0, `mem_write`=0, counters=0.
- `in_ready`=1 while reset is deasserted and the stage is empty.
- Reset asserted mid-operation discards the held instruction immediately and asynchronously. Nothing is replayed.

## Configuration
- Macro `COND_STATS_EN`.
- When defined:
  - `exec_count` increments on each accept with `ex=1`.
  - `squash_count` increments on each accept with `ex=0`.
  - Both saturate at all-ones (no wrap).
  - Both are cleared by `reset`.
- When undefined, the counter ports and logic are absent and `CNT_W` is unused.

## Structure
- Package `cond_pkg`:
  - `cond_e` enum for the 16 codes.
  - Flag index constants `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - `flag_w` bit constants `FW_NZ=1`, `FW_CV=0`.
- Sub-module `cond_check`: purely combinational `(cond, flags) -> ex` evaluator, instantiated once.
- `cond_logic` holds the flag register, the output register, the handshake logic and the optional counters.

## Test plan
- Reset, then an AL instruction with `flag_w`=11 and `alu_flags`=0100 → `out_valid`=1 next cycle, `cond_ex`=1, `flags`=0100.
- With `flags`=0100, EQ with `reg_w`=1 → `reg_write`=1. Next, NE with `reg_w`=1 → `cond_ex`=0, `reg_write`=0, `flags` unchanged.
- Back-to-back: CMP-like (AL, `flag_w`=11, `alu_flags`=1000), then GE → squashed; then LT → executes.
- `flag_w`=01, `alu_flags`=1111 from `flags`=0000 → `flags`=0011. Condition 1111 → squashed, `flags` hold.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs/flags stable. Release → one transfer per cycle.
- Assert `reset` mid-stall → `out_valid`=0 and `flags`=0000 without waiting for a clock edge. With `COND_STATS_EN` and `CNT_W`=2, five executes → `exec_count`=3 (saturated).
